// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: basic widths, the op
// encoding, sequencer states and the default divide iteration count.
package muldiv_ctrl_pkg;

   typedef logic        i1;
   typedef logic [31:0] i32;
   typedef logic [63:0] i64;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } muldiv_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DIV  = 1'b1
   } md_state_t;

   localparam int MD_DIV_CYCLES = 32;

   // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
   function automatic i32 abs32(input i32 x);
      return x[31] ? (~x + 32'd1) : x;
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> muldiv sequencer bundle: request side plus the HI/LO
// write strobes and data that feed the HI/LO register block.
interface muldiv_ctrl_if;
   import muldiv_ctrl_pkg::*;

   i1          valid;
   muldiv_op_t op;
   i32         a;
   i32         b;
   i1          flush;
   i1          ready;
   i1          hi_write;
   i1          lo_write;
   i32         hi_data;
   i32         lo_data;

   modport master (
      output valid, op, a, b, flush,
      input  ready, hi_write, lo_write, hi_data, lo_data
   );

   modport slave (
      input  valid, op, a, b, flush,
      output ready, hi_write, lo_write, hi_data, lo_data
   );

endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// div_iter: unsigned restoring divider, one quotient bit per i_iter cycle.
// o_quo/o_rem are the values after the iteration happening this cycle.
module div_iter
   import muldiv_ctrl_pkg::*;
(
   input  logic clk,
   input  i1    i_start,
   input  i1    i_iter,
   input  i32   i_dividend,
   input  i32   i_divisor,
   output i32   o_quo,
   output i32   o_rem
);

   i32          r_quo;
   i32          r_rem;
   i32          r_divisor;
   logic [32:0] w_shift;
   logic [32:0] w_diff;
   i1           w_ge;

   // Dividend bits shift out of r_quo into the partial remainder as quotient bits shift in.
   always_comb begin
      w_shift = {r_rem, r_quo[31]};
      w_diff  = w_shift - {1'b0, r_divisor};
      w_ge    = ~w_diff[32];
      o_rem   = w_ge ? w_diff[31:0] : w_shift[31:0];
      o_quo   = {r_quo[30:0], w_ge};
   end

   always_ff @(posedge clk) begin
      if (i_start) begin
         r_quo     <= i_dividend;
         r_rem     <= '0;
         r_divisor <= i_divisor;
      end else if (i_iter) begin
         r_quo <= o_quo;
         r_rem <= o_rem;
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: single-cycle MULT/MULTU/MTHI/MTLO, multi-cycle DIV/DIVU.
// Define MULDIV_EARLY_DIV0_EN to drop divides by zero at accept time.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = MD_DIV_CYCLES
) (
   input  logic            clk,
   input  logic            reset,
   muldiv_ctrl_if.slave    md
);

   localparam int CNT_W = $clog2(DIV_CYCLES);

   md_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   i1                r_neg_q;
   i1                r_neg_r;
   i1                r_hi_write;
   i1                r_lo_write;
   i32               r_hi_data;
   i32               r_lo_data;

   i1  w_accept;
   i1  w_is_div;
   i1  w_signed_div;
   i1  w_div0_skip;
   i1  w_start;
   i1  w_last;
   i32 w_div_a;
   i32 w_div_b;
   i32 w_quo;
   i32 w_rem;
   i64 w_prod_s;
   i64 w_prod_u;

   assign w_accept     = md.valid && (r_state == ST_IDLE) && !md.flush;
   assign w_is_div     = (md.op == MD_DIV) || (md.op == MD_DIVU);
   assign w_signed_div = (md.op == MD_DIV);
   assign w_div_a      = w_signed_div ? abs32(md.a) : md.a;
   assign w_div_b      = w_signed_div ? abs32(md.b) : md.b;
   assign w_prod_s     = $signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b});
   assign w_prod_u     = {32'd0, md.a} * {32'd0, md.b};
   assign w_last       = (r_cnt == CNT_W'(DIV_CYCLES - 1));

`ifdef MULDIV_EARLY_DIV0_EN
   assign w_div0_skip = (md.b == '0);
`else
   assign w_div0_skip = 1'b0;
`endif

   assign w_start = w_accept && w_is_div && !w_div0_skip;

   div_iter u_div_iter (
      .clk        (clk),
      .i_start    (w_start),
      .i_iter     (r_state == ST_DIV),
      .i_dividend (w_div_a),
      .i_divisor  (w_div_b),
      .o_quo      (w_quo),
      .o_rem      (w_rem)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_hi_write <= 1'b0;
         r_lo_write <= 1'b0;
         r_hi_data  <= '0;
         r_lo_data  <= '0;
      end else begin
         r_hi_write <= 1'b0;
         r_lo_write <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  case (md.op)
                     MD_MULT: begin
                        {r_hi_data, r_lo_data} <= w_prod_s;
                        r_hi_write <= 1'b1;
                        r_lo_write <= 1'b1;
                     end
                     MD_MULTU: begin
                        {r_hi_data, r_lo_data} <= w_prod_u;
                        r_hi_write <= 1'b1;
                        r_lo_write <= 1'b1;
                     end
                     MD_MTHI: begin
                        r_hi_data  <= md.a;
                        r_hi_write <= 1'b1;
                     end
                     MD_MTLO: begin
                        r_lo_data  <= md.a;
                        r_lo_write <= 1'b1;
                     end
                     MD_DIV, MD_DIVU: begin
                        if (w_start) begin
                           r_state <= ST_DIV;
                           r_cnt   <= '0;
                           r_neg_q <= w_signed_div && (md.a[31] ^ md.b[31]);
                           r_neg_r <= w_signed_div && md.a[31];
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ST_DIV: begin
               // A flush on the final iteration still wins: that op never writes.
               if (md.flush) begin
                  r_state <= ST_IDLE;
               end else if (w_last) begin
                  r_state    <= ST_IDLE;
                  r_lo_data  <= r_neg_q ? (~w_quo + 32'd1) : w_quo;
                  r_hi_data  <= r_neg_r ? (~w_rem + 32'd1) : w_rem;
                  r_hi_write <= 1'b1;
                  r_lo_write <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign md.ready    = (r_state == ST_IDLE);
   assign md.hi_write = r_hi_write;
   assign md.lo_write = r_lo_write;
   assign md.hi_data  = r_hi_data;
   assign md.lo_data  = r_lo_data;

endmodule
